// File: rtl/mul_share_arbiter_if.sv
// Request/response bus between requesters and the shared-multiplier arbiter.
// master = requester side, slave = arbiter side.
interface mul_share_arbiter_if #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
);
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [4*NREQ-1:0] req_a;
  logic [4*NREQ-1:0] req_b;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [IDW-1:0]    rsp_id;
  logic [7:0]        rsp_prod;

  modport master (
    output req_valid, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_prod
  );

  modport slave (
    input  req_valid, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_prod
  );
endinterface

// File: rtl/mul_share_arbiter.sv
// Round-robin arbiter sharing one combinational 4x4 multiplier among NREQ requesters.
// Define MUL_ARB_SETTLE_EN to add a SETTLE state giving the multiplier two cycles to settle.
module mul_share_arbiter #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  mul_share_arbiter_if.slave  bus,
  output logic [3:0]          mul_m,
  output logic [3:0]          mul_q,
  input  logic [7:0]          mul_p,
  output logic                busy
);

`ifdef MUL_ARB_SETTLE_EN
  typedef enum logic [1:0] {IDLE, CALC, SETTLE, RESP} state_t;
`else
  typedef enum logic [1:0] {IDLE, CALC, RESP} state_t;
`endif

  state_t         state;
  logic [IDW-1:0] ptr;
  logic [IDW-1:0] id;
  logic [IDW-1:0] gnt;
  logic           gnt_found;
  int             j;

  // Search starts one past the last winner so a held request waits at most NREQ grants.
  always_comb begin
    gnt       = '0;
    gnt_found = 1'b0;
    j         = 0;
    for (int k = 1; k <= NREQ; k++) begin
      j = (int'(ptr) + k) % NREQ;
      if (!gnt_found && bus.req_valid[j]) begin
        gnt_found = 1'b1;
        gnt       = IDW'(j);
      end
    end
  end

  always_comb begin
    bus.req_ready = '0;
    if (state == IDLE && gnt_found) bus.req_ready[gnt] = 1'b1;
  end

  assign busy = (state != IDLE);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= IDLE;
      mul_m        <= '0;
      mul_q        <= '0;
      bus.rsp_valid <= 1'b0;
      bus.rsp_id   <= '0;
      bus.rsp_prod <= '0;
      ptr          <= IDW'(NREQ - 1);
      id           <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (gnt_found) begin
            mul_m <= bus.req_a[4*gnt +: 4];
            mul_q <= bus.req_b[4*gnt +: 4];
            id    <= gnt;
            ptr   <= gnt;
            state <= CALC;
          end
        end
`ifdef MUL_ARB_SETTLE_EN
        CALC: state <= SETTLE;
        SETTLE: begin
          bus.rsp_prod  <= mul_p;
          bus.rsp_id    <= id;
          bus.rsp_valid <= 1'b1;
          state         <= RESP;
        end
`else
        CALC: begin
          bus.rsp_prod  <= mul_p;
          bus.rsp_id    <= id;
          bus.rsp_valid <= 1'b1;
          state         <= RESP;
        end
`endif
        RESP: begin
          if (bus.rsp_ready) begin
            bus.rsp_valid <= 1'b0;
            state         <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
